// File: rtl/lock_pkg.sv
// Shared types and constants for the code-lock sequencer: FSM states and LED/alarm driver commands.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        FAIL,
        ALARM,
        ALARM_OFF,
        PROG
    } lock_state_t;

    localparam logic [2:0] CMD_LED0      = 3'b000;
    localparam logic [2:0] CMD_LED1      = 3'b001;
    localparam logic [2:0] CMD_LED2      = 3'b010;
    localparam logic [2:0] CMD_LED3      = 3'b011;
    localparam logic [2:0] CMD_LED4      = 3'b100;
    localparam logic [2:0] CMD_ALARM_ON  = 3'b101;
    localparam logic [2:0] CMD_ALARM_OFF = 3'b110;

    localparam logic [2:0] CODE_DIGITS = 3'd4;

    function automatic logic is_bcd(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Shared state timer: loadable down-counter with a done flag, plus a blink divider
// that restarts at phase 1 and toggles every BLINK_DIV cycles.
module lock_timer #(
    parameter int CNT_W     = 8,
    parameter int BLINK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    input  logic             blink_restart,
    output logic             done,
    output logic             blink_phase
);

    localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [DIV_W-1:0] div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (enable && count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign done = (count_q == '0);

    // Divider free-runs; only its phase relative to the restart matters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            blink_phase <= 1'b1;
        end else if (blink_restart) begin
            div_q       <= '0;
            blink_phase <= 1'b1;
        end else if (div_q == DIV_LAST) begin
            div_q       <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/lock_controller.sv
// Code-lock sequencer: collects keypad digits, checks them against the stored code and drives the LED/alarm driver.
// Define LOCK_PROG_EN to allow reprogramming the code while the lock is open.
module lock_controller
    import lock_pkg::*;
#(
    parameter logic [15:0] DEFAULT_CODE = 16'h1234,
    parameter int          MAX_FAIL     = 3,
    parameter int          BLINK_DIV    = 12_500_000,
    parameter int          OPEN_CYCLES  = 100_000_000,
    parameter int          FAIL_CYCLES  = 50_000_000,
    parameter int          ALARM_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_clear,
    input  logic       prog_en,
    output logic [2:0] command,
    output logic       blink,
    output logic       unlock
);

    localparam int LONGEST_OF_TWO = (OPEN_CYCLES > FAIL_CYCLES) ? OPEN_CYCLES : FAIL_CYCLES;
    localparam int LONGEST        = (ALARM_CYCLES > LONGEST_OF_TWO) ? ALARM_CYCLES : LONGEST_OF_TWO;
    localparam int TIMER_W        = (LONGEST > 1) ? $clog2(LONGEST) : 1;
    localparam logic [2:0] MAX_FAIL_V = 3'(MAX_FAIL);

    lock_state_t        state_q, next_state;
    logic [2:0]         count_q, count_d;
    logic [15:0]        entry_q, entry_d;
    logic [2:0]         fail_q, fail_d, fail_inc;
    logic [15:0]        code_q;
    logic               digit_ok;
    logic               timer_load, timer_en, timer_done;
    logic               blink_restart, blink_phase;
    logic [TIMER_W-1:0] load_value;
    logic [2:0]         cmd_d;
    logic               blink_d, unlock_d;

`ifdef LOCK_PROG_EN
    logic [15:0] code_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= DEFAULT_CODE;
        end else begin
            code_q <= code_d;
        end
    end
`else
    logic unused_prog_en;

    assign code_q         = DEFAULT_CODE;
    assign unused_prog_en = prog_en;
`endif

    assign digit_ok = key_valid && !key_clear && is_bcd(key_digit);
    assign fail_inc = (fail_q >= MAX_FAIL_V) ? MAX_FAIL_V : fail_q + 3'd1;
    assign timer_en = (state_q == OPEN) || (state_q == FAIL) ||
                      (state_q == ALARM) || (state_q == ALARM_OFF);
    assign blink_restart = (next_state != state_q) &&
                           ((next_state == FAIL) || (next_state == ALARM));

    lock_timer #(
        .CNT_W     (TIMER_W),
        .BLINK_DIV (BLINK_DIV)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (timer_load),
        .load_value    (load_value),
        .enable        (timer_en),
        .blink_restart (blink_restart),
        .done          (timer_done),
        .blink_phase   (blink_phase)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            entry_q <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= next_state;
            count_q <= count_d;
            entry_q <= entry_d;
            fail_q  <= fail_d;
        end
    end

    // Timed states load the shared timer with CYCLES-1 so the state lasts exactly CYCLES.
    always_comb begin
        next_state = state_q;
        count_d    = count_q;
        entry_d    = entry_q;
        fail_d     = fail_q;
        timer_load = 1'b0;
        load_value = '0;
`ifdef LOCK_PROG_EN
        code_d     = code_q;
`endif
        case (state_q)
            IDLE, ENTRY: begin
                if (key_clear) begin
                    next_state = IDLE;
                    count_d    = '0;
                end else if (digit_ok) begin
                    entry_d    = {entry_q[11:0], key_digit};
                    count_d    = count_q + 3'd1;
                    next_state = (count_q == CODE_DIGITS - 3'd1) ? CHECK : ENTRY;
                end
            end
            CHECK: begin
                count_d    = '0;
                timer_load = 1'b1;
                if (entry_q == code_q) begin
                    next_state = OPEN;
                    fail_d     = '0;
                    load_value = TIMER_W'(OPEN_CYCLES - 1);
                end else if (fail_inc == MAX_FAIL_V) begin
                    next_state = ALARM;
                    fail_d     = fail_inc;
                    load_value = TIMER_W'(ALARM_CYCLES - 1);
                end else begin
                    next_state = FAIL;
                    fail_d     = fail_inc;
                    load_value = TIMER_W'(FAIL_CYCLES - 1);
                end
            end
            OPEN: begin
`ifdef LOCK_PROG_EN
                if (prog_en) begin
                    next_state = PROG;
                    count_d    = '0;
                end else if (timer_done) begin
                    next_state = IDLE;
                end
`else
                if (timer_done) begin
                    next_state = IDLE;
                end
`endif
            end
            FAIL: begin
                if (timer_done) begin
                    next_state = IDLE;
                end
            end
            ALARM: begin
                if (timer_done) begin
                    next_state = ALARM_OFF;
                    fail_d     = '0;
                    timer_load = 1'b1;
                    load_value = TIMER_W'(1);
                end
            end
            ALARM_OFF: begin
                if (timer_done) begin
                    next_state = IDLE;
                end
            end
`ifdef LOCK_PROG_EN
            PROG: begin
                if (key_clear) begin
                    next_state = IDLE;
                    count_d    = '0;
                end else if (digit_ok) begin
                    entry_d = {entry_q[11:0], key_digit};
                    if (count_q == CODE_DIGITS - 3'd1) begin
                        code_d     = {entry_q[11:0], key_digit};
                        count_d    = '0;
                        next_state = IDLE;
                    end else begin
                        count_d = count_q + 3'd1;
                    end
                end
            end
`endif
            default: begin
                next_state = IDLE;
                count_d    = '0;
            end
        endcase
    end

    // Outputs are registered from the current state, so they trail the state by one cycle.
    always_comb begin
        cmd_d    = CMD_LED0;
        blink_d  = 1'b1;
        unlock_d = 1'b0;
        case (state_q)
            IDLE, ENTRY: cmd_d = count_q;
            CHECK, FAIL: cmd_d = CMD_LED4;
            OPEN: begin
                cmd_d    = CMD_LED4;
                unlock_d = 1'b1;
            end
            ALARM:     cmd_d = CMD_ALARM_ON;
            ALARM_OFF: cmd_d = CMD_ALARM_OFF;
            PROG: begin
                cmd_d    = count_q;
                unlock_d = 1'b1;
            end
            default: cmd_d = CMD_LED0;
        endcase
        if (state_q == FAIL || state_q == ALARM) begin
            blink_d = blink_phase;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            command <= CMD_LED0;
            blink   <= 1'b1;
            unlock  <= 1'b0;
        end else begin
            command <= cmd_d;
            blink   <= blink_d;
            unlock  <= unlock_d;
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
// Self-checking bench for lock_controller: directed scenarios with literal expectations plus
// randomized keypad traffic compared every cycle against a behavioural model.
module tb_lock_controller;

    localparam int BLINK_DIV    = 4;
    localparam int OPEN_CYCLES  = 20;
    localparam int FAIL_CYCLES  = 16;
    localparam int ALARM_CYCLES = 40;
    localparam int MAX_FAIL     = 3;

    localparam int ACT_IDLE      = 0;
    localparam int ACT_CHECK     = 1;
    localparam int ACT_OPEN      = 2;
    localparam int ACT_FAIL      = 3;
    localparam int ACT_ALARM     = 4;
    localparam int ACT_ALARM_OFF = 5;
    localparam int ACT_PROG      = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       key_clear = 1'b0;
    logic       prog_en = 1'b0;
    logic [2:0] command;
    logic       blink;
    logic       unlock;

    int tests_run = 0;
    int tests_failed = 0;

    int m_act;
    int m_age;
    int m_fails;
    int m_q[$];
    int m_code[4];

    lock_controller #(
        .DEFAULT_CODE (16'h1234),
        .MAX_FAIL     (MAX_FAIL),
        .BLINK_DIV    (BLINK_DIV),
        .OPEN_CYCLES  (OPEN_CYCLES),
        .FAIL_CYCLES  (FAIL_CYCLES),
        .ALARM_CYCLES (ALARM_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .key_clear (key_clear),
        .prog_en   (prog_en),
        .command   (command),
        .blink     (blink),
        .unlock    (unlock)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [2:0] exp_cmd,
                               input logic exp_blink, input logic exp_unlock);
        tests_run++;
        if (command !== exp_cmd) begin
            tests_failed++;
            $display("[TB] FAIL %s command: got %b, want %b (t=%0t)", name, command, exp_cmd, $time);
        end
        tests_run++;
        if (blink !== exp_blink) begin
            tests_failed++;
            $display("[TB] FAIL %s blink: got %b, want %b (t=%0t)", name, blink, exp_blink, $time);
        end
        tests_run++;
        if (unlock !== exp_unlock) begin
            tests_failed++;
            $display("[TB] FAIL %s unlock: got %b, want %b (t=%0t)", name, unlock, exp_unlock, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] digit,
                                 input logic clear, input logic prog);
        @(negedge clk);
        key_valid = valid;
        key_digit = digit;
        key_clear = clear;
        prog_en   = prog;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    // ---------------- behavioural model ----------------
    task automatic model_reset();
        m_act   = ACT_IDLE;
        m_age   = 0;
        m_fails = 0;
        m_q.delete();
        m_code  = '{1, 2, 3, 4};
    endtask

    task automatic model_enter(input int act);
        m_act = act;
        m_age = 0;
    endtask

    task automatic model_outputs(output logic [2:0] cmd, output logic bl, output logic ul);
        cmd = 3'd0;
        bl  = 1'b1;
        ul  = 1'b0;
        case (m_act)
            ACT_IDLE:      cmd = 3'(m_q.size());
            ACT_CHECK:     cmd = 3'd4;
            ACT_OPEN:      begin cmd = 3'd4; ul = 1'b1; end
            ACT_FAIL:      begin cmd = 3'd4; bl = ((m_age / BLINK_DIV) % 2) == 0; end
            ACT_ALARM:     begin cmd = 3'd5; bl = ((m_age / BLINK_DIV) % 2) == 0; end
            ACT_ALARM_OFF: cmd = 3'd6;
            ACT_PROG:      begin cmd = 3'(m_q.size()); ul = 1'b1; end
            default:       cmd = 3'd7;
        endcase
    endtask

    task automatic model_step(input logic valid, input logic [3:0] digit,
                              input logic clear, input logic prog);
        bit ok;
        bit match;
        ok = valid && !clear && (digit <= 4'd9);
        case (m_act)
            ACT_IDLE: begin
                if (clear) m_q.delete();
                else if (ok) begin
                    m_q.push_back(int'(digit));
                    if (m_q.size() == 4) model_enter(ACT_CHECK);
                end
            end
            ACT_CHECK: begin
                match = 1'b1;
                for (int i = 0; i < 4; i++) if (m_q[i] != m_code[i]) match = 1'b0;
                m_q.delete();
                if (match) begin
                    m_fails = 0;
                    model_enter(ACT_OPEN);
                end else begin
                    if (m_fails < MAX_FAIL) m_fails++;
                    model_enter((m_fails == MAX_FAIL) ? ACT_ALARM : ACT_FAIL);
                end
            end
            ACT_OPEN: begin
`ifdef LOCK_PROG_EN
                if (prog) begin
                    m_q.delete();
                    model_enter(ACT_PROG);
                end else if (m_age == OPEN_CYCLES - 1) model_enter(ACT_IDLE);
                else m_age++;
`else
                if (m_age == OPEN_CYCLES - 1) model_enter(ACT_IDLE);
                else m_age++;
`endif
            end
            ACT_FAIL: begin
                if (m_age == FAIL_CYCLES - 1) model_enter(ACT_IDLE);
                else m_age++;
            end
            ACT_ALARM: begin
                if (m_age == ALARM_CYCLES - 1) begin
                    m_fails = 0;
                    model_enter(ACT_ALARM_OFF);
                end else m_age++;
            end
            ACT_ALARM_OFF: begin
                if (m_age == 1) model_enter(ACT_IDLE);
                else m_age++;
            end
            ACT_PROG: begin
                if (clear) begin
                    m_q.delete();
                    model_enter(ACT_IDLE);
                end else if (ok) begin
                    m_q.push_back(int'(digit));
                    if (m_q.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_code[i] = m_q[i];
                        m_q.delete();
                        model_enter(ACT_IDLE);
                    end
                end
            end
            default: model_enter(ACT_IDLE);
        endcase
`ifndef LOCK_PROG_EN
        begin
            logic unused_prog;
            unused_prog = prog;
        end
`endif
    endtask

    // Outputs after an edge reflect the model's situation during the cycle before that edge.
    always @(posedge clk) begin
        logic [2:0] e_cmd;
        logic       e_blink;
        logic       e_unlock;
        if (!rst_n) begin
            model_reset();
            e_cmd    = 3'd0;
            e_blink  = 1'b1;
            e_unlock = 1'b0;
        end else begin
            model_outputs(e_cmd, e_blink, e_unlock);
            model_step(key_valid, key_digit, key_clear, prog_en);
        end
        #1;
        checkOutput("cycle", e_cmd, e_blink, e_unlock);
    end

    // ---------------- directed scenarios ----------------
    task automatic press4(input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] d2, input logic [3:0] d3);
        applyStimulus(1'b1, d0, 1'b0, 1'b0);
        applyStimulus(1'b1, d1, 1'b0, 1'b0);
        applyStimulus(1'b1, d2, 1'b0, 1'b0);
        applyStimulus(1'b1, d3, 1'b0, 1'b0);
    endtask

    task automatic check_open(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3);
        applyStimulus(1'b1, d0, 1'b0, 1'b0);
        applyStimulus(1'b1, d1, 1'b0, 1'b0);
        applyStimulus(1'b1, d2, 1'b0, 1'b0);
        checkOutput("entry_1", 3'b001, 1'b1, 1'b0);
        applyStimulus(1'b1, d3, 1'b0, 1'b0);
        checkOutput("entry_2", 3'b010, 1'b1, 1'b0);
        idle(1);
        checkOutput("entry_3", 3'b011, 1'b1, 1'b0);
        idle(1);
        checkOutput("check", 3'b100, 1'b1, 1'b0);
        idle(1);
        checkOutput("open_first", 3'b100, 1'b1, 1'b1);
        idle(19);
        checkOutput("open_last", 3'b100, 1'b1, 1'b1);
        idle(1);
        checkOutput("open_done", 3'b000, 1'b1, 1'b0);
    endtask

    task automatic check_fail(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3);
        press4(d0, d1, d2, d3);
        idle(3);
        checkOutput("fail_first", 3'b100, 1'b1, 1'b0);
        idle(4);
        checkOutput("fail_blink_low", 3'b100, 1'b0, 1'b0);
        idle(4);
        checkOutput("fail_blink_high", 3'b100, 1'b1, 1'b0);
        idle(7);
        checkOutput("fail_last", 3'b100, 1'b0, 1'b0);
        idle(1);
        checkOutput("fail_done", 3'b000, 1'b1, 1'b0);
    endtask

    task automatic start_alarm();
        press4(4'd5, 4'd5, 4'd5, 4'd5);
        idle(3);
        checkOutput("alarm_first", 3'b101, 1'b1, 1'b0);
        idle(4);
        checkOutput("alarm_blink_low", 3'b101, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 3'b000, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset", 3'b000, 1'b1, 1'b0);

        check_open(4'd1, 4'd2, 4'd3, 4'd4);
        check_fail(4'd1, 4'd2, 4'd3, 4'd5);

        // Clear with a simultaneous digit: digit dropped, no extra failure recorded.
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b0);
        idle(1);
        checkOutput("clear_pre", 3'b010, 1'b1, 1'b0);
        idle(1);
        checkOutput("clear_cmd", 3'b000, 1'b1, 1'b0);
        check_fail(4'd9, 4'd9, 4'd9, 4'd9);

        // Third consecutive failure: full alarm then alarm-off, then the right code still opens.
        start_alarm();
        idle(35);
        checkOutput("alarm_last", 3'b101, 1'b0, 1'b0);
        idle(1);
        checkOutput("alarm_off_1", 3'b110, 1'b1, 1'b0);
        idle(1);
        checkOutput("alarm_off_2", 3'b110, 1'b1, 1'b0);
        idle(1);
        checkOutput("alarm_done", 3'b000, 1'b1, 1'b0);
        check_open(4'd1, 4'd2, 4'd3, 4'd4);

        // Reset in the middle of an alarm.
        check_fail(4'd7, 4'd7, 4'd7, 4'd7);
        check_fail(4'd8, 4'd8, 4'd8, 4'd8);
        start_alarm();
        idle(3);
        pulse_reset();
        check_open(4'd1, 4'd2, 4'd3, 4'd4);

`ifdef LOCK_PROG_EN
        pulse_reset();
        press4(4'd1, 4'd2, 4'd3, 4'd4);
        idle(2);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
        checkOutput("prog_entry", 3'b000, 1'b1, 1'b1);
        applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
        idle(3);
        check_fail(4'd1, 4'd2, 4'd3, 4'd4);
        check_open(4'd9, 4'd8, 4'd7, 4'd6);
`endif

        // Randomized traffic, biased toward the currently stored code.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic       v;
            logic [3:0] d;
            logic       c;
            logic       p;
            v = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) < 6 && m_q.size() < 4) d = 4'(m_code[m_q.size()]);
            else d = 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 15) == 0);
            p = ($urandom_range(0, 7) == 0);
            applyStimulus(v, d, c, p);
            rst_n = ($urandom_range(0, 599) != 0);
        end
        rst_n = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
